// File: rtl/matc_stream_reader_pkg.sv
// Shared constants, state encoding and beat layout for the result-matrix readout path.
// The addr->row/col helper is also used by the matrix-multiply writer.
package matc_stream_reader_pkg;

    localparam int DATA_W = 19;
    localparam int DIM    = 8;
    localparam int ADDR_W = 6;
    localparam int SUM_W  = 25;
    localparam int N      = DIM * DIM;
    localparam int IDX_W  = $clog2(DIM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } rc_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] data;
        logic [IDX_W-1:0]         row;
        logic [IDX_W-1:0]         col;
        logic                     last;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    function automatic rc_t addr_to_rc(input logic [ADDR_W-1:0] addr);
        rc_t rc;
        rc.row = IDX_W'(int'(addr) / DIM);
        rc.col = IDX_W'(int'(addr) % DIM);
        return rc;
    endfunction

endpackage

// File: rtl/matc_stream_reader_if.sv
// RAM read port plus the downstream element stream of the result reader.
interface matc_stream_reader_if;
    import matc_stream_reader_pkg::*;

    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] rd_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]         out_row;
    logic [IDX_W-1:0]         out_col;
    logic                     out_last;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output out_valid, out_data, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  out_valid, out_data, out_row, out_col, out_last,
        output out_ready
    );

endinterface

// File: rtl/matc_stream_reader_fifo.sv
// Two-entry valid/ready FIFO; outputs come straight from storage so valid never
// depends on ready. The writer guarantees it never writes while full.
module stream_skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdata,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_rdata,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic         w_pop;

    assign w_pop   = (r_count != 2'd0) && i_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_wr) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, i_wr} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/matc_stream_reader.sv
// Reads the DIM x DIM result matrix out of the result RAM in row-major order and
// streams it with row/col tags and a running signed checksum.
module matc_stream_reader
    import matc_stream_reader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    matc_stream_reader_if.master    bus,
    output logic                    o_busy,
    output logic                    o_done,
    output logic signed [SUM_W-1:0] o_checksum
);
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_W-1:0]       r_issue_addr;
    logic                    r_inflight;
    logic [ADDR_W-1:0]       r_inflight_addr;
    logic signed [SUM_W-1:0] r_checksum;
    logic                    w_issue;
    logic                    w_pop;
    logic                    w_start_acc;
    logic                    w_fifo_valid;
    logic [1:0]              w_fifo_count;
    logic [2:0]              w_occupancy;
    rc_t                     w_rc;
    beat_t                   w_wbeat;
    beat_t                   w_obeat;

    assign w_pop       = w_fifo_valid & bus.out_ready;
    assign w_start_acc = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
    // Entries buffered or in flight once this cycle's pop has left.
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) w_state_nxt = ST_READ;
            end
            ST_READ: begin
                w_issue = (w_occupancy < 3'd2);
                if (w_issue && r_issue_addr == ADDR_W'(N - 1)) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!r_inflight && (w_fifo_count == 2'd0 || (w_fifo_count == 2'd1 && w_pop)))
                    w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_issue_addr    <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
            r_checksum      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (w_start_acc) begin
                r_issue_addr <= '0;
            end else if (w_issue) begin
                r_issue_addr <= r_issue_addr + ADDR_W'(1);
            end
            if (w_issue) begin
                r_inflight_addr <= r_issue_addr;
            end
            if (w_start_acc) begin
                r_checksum <= '0;
            end else if (w_pop) begin
                r_checksum <= r_checksum
                            + {{(SUM_W - DATA_W){w_obeat.data[DATA_W-1]}}, w_obeat.data};
            end
        end
    end

    assign w_rc          = addr_to_rc(r_inflight_addr);
    assign w_wbeat.data  = bus.rd_data;
    assign w_wbeat.row   = w_rc.row;
    assign w_wbeat.col   = w_rc.col;
    assign w_wbeat.last  = (r_inflight_addr == ADDR_W'(N - 1));

    stream_skid_fifo2 #(
        .W (BEAT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (r_inflight),
        .i_wdata (w_wbeat),
        .o_valid (w_fifo_valid),
        .i_ready (bus.out_ready),
        .o_rdata (w_obeat),
        .o_count (w_fifo_count)
    );

    assign bus.rd_en     = w_issue;
    assign bus.rd_addr   = r_issue_addr;
    assign bus.out_valid = w_fifo_valid;
    assign bus.out_data  = w_obeat.data;
    assign bus.out_row   = w_obeat.row;
    assign bus.out_col   = w_obeat.col;
    assign bus.out_last  = w_obeat.last;

    assign o_busy     = (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign o_done     = (r_state == ST_DONE);
    assign o_checksum = r_checksum;

endmodule
